// File: rtl/game_sync_tx.sv
// UART 8N1 transmitter for the inter-board game link: repeats a READY byte while
// this board waits with PLAY clicked, and sends a 2-byte SCORE frame on GAME->SCORE.
module game_sync_tx #(
  parameter int          CLKS_PER_BIT  = 564,
  parameter int          REPEAT_CYCLES = 650000,
  parameter logic [7:0]  READY_BYTE    = 8'hA5,
  parameter logic [7:0]  SCORE_HDR     = 8'h5C
) (
  input  logic       pclk,
  input  logic       rst_d,
  input  logic [1:0] state,
  input  logic       local_ready,
  input  logic [7:0] score,
  output logic       tx,
  output logic       busy,
  output logic       frame_sent
);

  localparam logic [1:0] G_IDLE  = 2'b00;
  localparam logic [1:0] G_WAIT  = 2'b01;
  localparam logic [1:0] G_GAME  = 2'b10;
  localparam logic [1:0] G_SCORE = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_START = 2'b01;
  localparam logic [1:0] S_DATA  = 2'b10;
  localparam logic [1:0] S_STOP  = 2'b11;

  localparam int CW = (CLKS_PER_BIT  > 1) ? $clog2(CLKS_PER_BIT)  : 1;
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  logic [1:0]    prev_state;
  logic [RW-1:0] rep_cnt;
  logic          ready_req;
  logic          score_req;
  logic [7:0]    score_lat;
  logic          pend_second;
  logic [7:0]    second_byte;

  logic [1:0]    ser_st;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          last_byte;

  logic          rc;
  logic          score_edge;
  logic          bit_end;
  logic          ser_free;
  logic          load_second;
  logic          load_score;
  logic          load_ready;
  logic          load;
  logic [7:0]    load_byte;

  assign rc          = (state == G_WAIT) && local_ready;
  assign score_edge  = (prev_state == G_GAME) && (state == G_SCORE);
  assign bit_end     = (bit_cnt == CW'(CLKS_PER_BIT - 1));
  // The serializer can accept a byte on the very edge its stop bit ends.
  assign ser_free    = (ser_st == S_IDLE) || ((ser_st == S_STOP) && bit_end);
  assign load_second = ser_free && pend_second;
  assign load_score  = ser_free && !pend_second && score_req;
  assign load_ready  = ser_free && !pend_second && !score_req && ready_req && rc;
  assign load        = load_second || load_score || load_ready;

  // NOTE: combinational blocks assign a default first so no path leaves a value held (no latch).
  always_comb begin
    load_byte = 8'h00;
    if (load_second)     load_byte = second_byte;
    else if (load_score) load_byte = SCORE_HDR;
    else if (load_ready) load_byte = READY_BYTE;
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous to pclk.
  always_ff @(posedge pclk) begin
    if (rst_d) begin
      prev_state  <= G_IDLE;
      rep_cnt     <= '0;
      ready_req   <= 1'b0;
      score_req   <= 1'b0;
      score_lat   <= 8'h00;
      pend_second <= 1'b0;
      second_byte <= 8'h00;
    end else begin
      prev_state <= state;

      if (!rc)                                   rep_cnt <= '0;
      else if (rep_cnt == RW'(REPEAT_CYCLES - 1)) rep_cnt <= '0;
      else                                       rep_cnt <= rep_cnt + RW'(1);

      // At most one READY pending; dropping rc cancels one that has not started.
      if (!rc)                   ready_req <= 1'b0;
      else if (rep_cnt == '0)    ready_req <= 1'b1;
      else if (load_ready)       ready_req <= 1'b0;

      if (score_edge) begin
        score_req <= 1'b1;
        score_lat <= score;
      end else if (load_score) begin
        score_req <= 1'b0;
      end

      // The second SCORE byte is captured with the header so later edges cannot corrupt it.
      if (load_score) begin
        pend_second <= 1'b1;
        second_byte <= score_lat;
      end else if (load_second) begin
        pend_second <= 1'b0;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst_d) begin
      ser_st    <= S_IDLE;
      tx        <= 1'b1;
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      last_byte <= 1'b0;
    end else if (load) begin
      ser_st    <= S_START;
      tx        <= 1'b0;
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      shreg     <= load_byte;
      last_byte <= load_second || load_ready;
    end else begin
      case (ser_st)
        S_START: begin
          if (bit_end) begin
            ser_st  <= S_DATA;
            bit_cnt <= '0;
            tx      <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            shreg   <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              ser_st <= S_STOP;
              tx     <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            ser_st  <= S_IDLE;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
          ser_st <= S_IDLE;
          tx     <= 1'b1;
        end
      endcase
    end
  end

  assign busy       = (ser_st != S_IDLE);
  assign frame_sent = (ser_st == S_STOP) && bit_end && last_byte;

endmodule

// File: tb/tb_game_sync_tx.sv
// Directed bench for game_sync_tx with CLKS_PER_BIT=4, REPEAT_CYCLES=100.
module tb_game_sync_tx;

  localparam logic [1:0] G_IDLE  = 2'b00;
  localparam logic [1:0] G_WAIT  = 2'b01;
  localparam logic [1:0] G_GAME  = 2'b10;
  localparam logic [1:0] G_SCORE = 2'b11;

  logic       pclk;
  logic       rst_d;
  logic [1:0] state;
  logic       local_ready;
  logic [7:0] score;
  logic       tx;
  logic       busy;
  logic       frame_sent;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  game_sync_tx #(
    .CLKS_PER_BIT (4),
    .REPEAT_CYCLES(100),
    .READY_BYTE   (8'hA5),
    .SCORE_HDR    (8'h5C)
  ) dut (
    .pclk       (pclk),
    .rst_d      (rst_d),
    .state      (state),
    .local_ready(local_ready),
    .score      (score),
    .tx         (tx),
    .busy       (busy),
    .frame_sent (frame_sent)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Returns the negedge cycle at which tx is first seen low, or -1 on timeout.
  task automatic wait_start(input int budget, output int e);
    e = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge pclk);
      if (tx === 1'b0) begin
        e = cyc;
        break;
      end
    end
    if (e < 0) check("start_timeout", 32'd0, 32'd1);
  endtask

  // Entered at the negedge where the start bit was first seen; exits at the final stop cycle.
  task automatic recv_byte(input logic fs_exp, output logic [7:0] b);
    logic v0;
    b = 8'h00;
    repeat (3) @(negedge pclk);
    check("start_hold", tx, 1'b0);
    check("busy_in_byte", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      v0 = tx;
      repeat (3) @(negedge pclk);
      check("bit_hold", tx, v0);
      b[i] = v0;
    end
    @(negedge pclk);
    check("stop_first", tx, 1'b1);
    check("fs_early", frame_sent, 1'b0);
    repeat (2) @(negedge pclk);
    check("fs_early", frame_sent, 1'b0);
    @(negedge pclk);
    check("stop_last", tx, 1'b1);
    check("fs_end", frame_sent, fs_exp);
  endtask

  task automatic quiet(input int n, input string tag);
    int lows = 0;
    int busies = 0;
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busies++;
      if (frame_sent !== 1'b0) pulses++;
    end
    check({tag, "_tx"}, 32'(lows), 32'd0);
    check({tag, "_busy"}, 32'(busies), 32'd0);
    check({tag, "_fs"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    int t0;
    int e;
    int e2;
    int n;
    logic [7:0] b;

    rst_d = 1'b1;
    state = G_IDLE;
    local_ready = 1'b0;
    score = 8'h00;

    // 1: reset values, then idle silence
    repeat (3) @(negedge pclk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_fs", frame_sent, 1'b0);
    rst_d = 1'b0;
    quiet(200, "idle");

    // 2: READY byte timing and repeat period
    state = G_WAIT;
    local_ready = 1'b1;
    t0 = cyc + 1;
    wait_start(10, e);
    check("ready_start", 32'(e), 32'(t0 + 1));
    recv_byte(1'b1, b);
    check("ready_byte", b, 8'hA5);
    check("ready_fs_time", 32'(cyc), 32'(t0 + 40));
    @(negedge pclk);
    check("idle_after_ready", busy, 1'b0);
    wait_start(100, e2);
    check("ready_repeat", 32'(e2), 32'(t0 + 101));
    recv_byte(1'b1, b);
    check("ready_byte2", b, 8'hA5);

    // 4: leave WAIT mid-byte; the byte completes and nothing follows
    wait_start(100, e);
    check("ready_third", 32'(e), 32'(t0 + 201));
    fork
      recv_byte(1'b1, b);
      begin
        repeat (10) @(negedge pclk);
        state = G_GAME;
      end
    join
    check("ready_trunc_byte", b, 8'hA5);
    quiet(250, "after_game");

    // 3: GAME->SCORE sends header then score back-to-back
    score = 8'h2A;
    state = G_SCORE;
    n = cyc;
    wait_start(10, e);
    check("score_start", 32'(e), 32'(n + 2));
    recv_byte(1'b0, b);
    check("score_hdr", b, 8'h5C);
    wait_start(2, e2);
    check("score_b2b", 32'(e2), 32'(e + 40));
    recv_byte(1'b1, b);
    check("score_val", b, 8'h2A);
    quiet(150, "after_score");

    // 6: score edge during an in-flight READY byte
    state = G_IDLE;
    @(negedge pclk);
    state = G_WAIT;
    wait_start(10, e);
    fork
      recv_byte(1'b1, b);
      begin
        repeat (15) @(negedge pclk);
        state = G_GAME;
        score = 8'h3C;
        @(negedge pclk);
        state = G_SCORE;
        @(negedge pclk);
        score = 8'hFF;
      end
    join
    check("inflight_ready", b, 8'hA5);
    wait_start(2, e2);
    check("score_after_ready", 32'(e2), 32'(e + 40));
    recv_byte(1'b0, b);
    check("score_hdr2", b, 8'h5C);
    wait_start(2, e);
    check("score_b2b2", 32'(e), 32'(e2 + 40));
    recv_byte(1'b1, b);
    check("score_latched", b, 8'h3C);
    quiet(50, "after_score2");

    // 5: reset during a data bit
    state = G_WAIT;
    local_ready = 1'b1;
    wait_start(10, e);
    repeat (10) @(negedge pclk);
    rst_d = 1'b1;
    state = G_IDLE;
    local_ready = 1'b0;
    @(negedge pclk);
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_fs", frame_sent, 1'b0);
    repeat (2) @(negedge pclk);
    rst_d = 1'b0;
    quiet(200, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
